// File: rtl/rng_share_arb_pkg.sv
// Shared types and helpers for the RNG share arbiter.
//   state_e : arbiter FSM states (2-bit encoding)
//   rr_pick : round-robin winner search over up to MAX_REQ request lines
package rng_share_arb_pkg;

  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_READY = 2'd1,
    ST_GRANT = 2'd2
  } state_e;

  // Returns the index of the first set bit of req at or after ptr, wrapping
  // modulo n. Returns 0 when no bit is set (callers qualify with |req).
  function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                         input logic [2:0]         ptr,
                                         input int                 n);
    logic [2:0] win;
    int         j;
    win = '0;
    // Walk from the far end so the nearest hit overwrites the others.
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < n) begin
        j = (int'(ptr) + k) % n;
        if (req[j]) win = 3'(j);
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker.
//   req_i    : request vector (already gated by the caller)
//   ptr_i    : round-robin start index
//   winner_o : index of first set request at or after ptr_i (wrapping)
//   any_o    : at least one request set
// Rotates req so ptr_i lands on bit 0, priority-encodes, then un-rotates.
module rr_priority_picker
  import rng_share_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PW-1:0]      ptr_i,
  output logic [PW-1:0]      winner_o,
  output logic               any_o
);

  logic [MAX_REQ-1:0] rot;
  logic [2:0]         off;
  int                 sum;

  always_comb begin
    rot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int idx;
      idx = int'(ptr_i) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      rot[i] = req_i[idx];
    end
    // After rotation the search always starts at bit 0.
    off = rr_pick(rot, 3'd0, NUM_REQ);
    sum = int'(ptr_i) + int'(off);
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    winner_o = PW'(sum);
    any_o    = |req_i;
  end

endmodule

// File: rtl/rng_share_arbiter.sv
// Round-robin arbiter sharing one LFSR random source among NUM_REQ requesters.
// Between grants the LFSR is advanced FRESH_CYCLES times so every granted word
// is fresh.
//   clk, rst   : clock, asynchronous active-high reset
//   ena        : design enable; low freezes state, counter and pointer
//   req        : level requests, held until gnt seen
//   rnd_in     : current LFSR output
//   lfsr_en    : LFSR advance enable (combinational, FILL && ena)
//   gnt        : one-hot grant, single-cycle pulse
//   rnd_out    : last granted random word
//   rnd_valid  : high together with gnt
//   ready      : fresh word available (READY state)
//   grant_cnt  : grant counter, present only with RNG_SHARE_ARB_STATS_EN
// Optional feature macro: RNG_SHARE_ARB_STATS_EN.
module rng_share_arbiter
  import rng_share_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int WIDTH        = 16,
  parameter int FRESH_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic [NUM_REQ-1:0] req,
  input  logic [WIDTH-1:0]   rnd_in,
  output logic               lfsr_en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [WIDTH-1:0]   rnd_out,
  output logic               rnd_valid,
`ifdef RNG_SHARE_ARB_STATS_EN
  output logic [15:0]        grant_cnt,
`endif
  output logic               ready
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(FRESH_CYCLES + 1);
  localparam logic [CW-1:0] FILL_LAST = CW'(FRESH_CYCLES - 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [WIDTH-1:0]   rnd_q, rnd_d;
  logic               vld_q, vld_d;

  logic [NUM_REQ-1:0] req_gated;
  logic [PW-1:0]      win;
  logic               any;

  // Requests are only looked at in READY, so an X on an idle line elsewhere
  // never reaches the picker.
  assign req_gated = (state_q == ST_READY) ? req : '0;

  rr_priority_picker #(.NUM_REQ(NUM_REQ), .PW(PW)) u_pick (
    .req_i    (req_gated),
    .ptr_i    (ptr_q),
    .winner_o (win),
    .any_o    (any)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gnt_d   = '0;
    rnd_d   = rnd_q;
    vld_d   = 1'b0;
    lfsr_en = 1'b0;
    ready   = 1'b0;
    case (state_q)
      ST_FILL: begin
        if (ena) begin
          lfsr_en = 1'b1;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == FILL_LAST) state_d = ST_READY;
        end
      end
      ST_READY: begin
        ready = 1'b1;
        if (ena && any) begin
          gnt_d[win] = 1'b1;
          rnd_d      = rnd_in;
          vld_d      = 1'b1;
          ptr_d      = (win == PW'(NUM_REQ - 1)) ? '0 : win + PW'(1);
          state_d    = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // A registered grant always completes, even with ena low.
        cnt_d   = '0;
        state_d = ST_FILL;
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FILL;
      cnt_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      rnd_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      rnd_q   <= rnd_d;
      vld_q   <= vld_d;
    end
  end

  assign gnt       = gnt_q;
  assign rnd_out   = rnd_q;
  assign rnd_valid = vld_q;

`ifdef RNG_SHARE_ARB_STATS_EN
  logic [15:0] gcnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    gcnt_q <= '0;
    else if (state_q == ST_GRANT) gcnt_q <= gcnt_q + 16'd1;
  end
  assign grant_cnt = gcnt_q;
`endif

endmodule
